policy_ctrl: RTL and testbench
==============================

Name: policy_ctrl

Overview:
- Sequential controller that turns the current tic-tac-toe board into the agent's next move.
- Scans the 9 Q-values for the presented board over a shared, 1-cycle-latency Q-table read port.
- Masks occupied cells and keeps a running signed maximum; ties go to the lowest cell index.
- Returns the chosen action on a valid/ready handshake. Sits between the game FSM (requester) and the Q-table RAM.

Parameters:
- Q_W, 8, Q-value width (two's-complement signed).
- N_CELLS, 9, board cells / actions per state.
- LFSR_SEED, 8'hA5, exploration LFSR reset value; must be nonzero.
- EPS_THRESH, 8'd26, exploration threshold (about 10%); used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  board presented.
- req_ready  out  1  controller can accept a board.
- req_state  in  18  board; cell i = bits [2i+1:2i]; 00 empty, 01 X, 10 O, 11 treated as occupied.
- q_rd_en  out  1  Q-table read strobe.
- q_rd_state  out  18  read address, state part (captured board).
- q_rd_action  out  4  read address, action part (0..8).
- q_rd_data  in  Q_W  signed Q-value, valid the cycle after q_rd_en.
- act_valid  out  1  result valid.
- act_ready  in  1  consumer accepts result.
- act_action  out  4  chosen cell 0..8; 4'hF = no legal move.
- act_none  out  1  board full / no legal cell.
- act_qmax  out  Q_W  Q-value of the chosen cell; 0 when act_none.
- act_explore  out  1  result came from the exploration path; constant 0 without the feature.

Behaviour:
- States: IDLE, SCAN, DRAIN, DONE.
- Reset (rst_n=0 at an edge), from any state:
  - state goes to IDLE; req_ready=1; q_rd_en=0; q_rd_action=0; q_rd_state=0.
  - act_valid=0, act_action=4'hF, act_none=0, act_qmax=0, act_explore=0; LFSR=LFSR_SEED.
- Reset mid-scan abandons the request; no result is produced.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready (cycle T): capture req_state, clear the "found" flag, go to SCAN.
- SCAN:
  - Cycles T+1..T+9: q_rd_en=1; q_rd_action = 0..8 in order; q_rd_state = captured board.
  - All 9 cells are read regardless of occupancy, so latency is fixed.
- Data compare:
  - q_rd_data for action k arrives one cycle after its read and is compared only if cell k is empty.
  - First empty cell loads max/index unconditionally, so -128 is a valid maximum.
  - Later cells update only on strict signed greater-than; equal values keep the lower index.
- DRAIN (T+10): consume the action-8 data, then go to DONE.
- DONE (from T+11):
  - act_valid=1; outputs held stable while act_ready=0.
  - act_valid&&act_ready returns to IDLE next cycle, with act_valid=0 and req_ready=1.
  - Minimum request-to-request spacing is 12 cycles.
- No empty cell: act_none=1, act_action=4'hF, act_qmax=0.
- req_ready=0 in SCAN, DRAIN and DONE; req_valid is ignored there.
- Captured board is immune to req_state changes after acceptance.
- q_rd_data is ignored whenever no read was issued the previous cycle.

Optional Feature:
- Macro: POLICY_CTRL_EPS_EXPLORE_EN.
- Defined:
  - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advances every cycle out of reset.
  - At acceptance, lfsr[7:0] < EPS_THRESH sets an explore flag and captures start = lfsr[3:0] mod 9.
  - At DONE with explore set: act_action = first empty cell scanning start, start+1, ... mod 9. act_qmax = that cell's Q-value (recorded during the scan). act_explore=1.
  - With no empty cell, the result is the act_none result and act_explore=0.
- Undefined: no LFSR, purely greedy, act_explore tied 0; EPS_THRESH unused.

Decomposition:
- Shared package policy_pkg:
  - Q_W, N_CELLS, CELL_EMPTY=2'b00, ACT_NONE=4'hF.
  - FSM state encoding (IDLE/SCAN/DRAIN/DONE).
  - The board cell-extraction function.
- One sub-module: lfsr8 (seeded 8-bit LFSR, enable input), instantiated only under the macro.

Test Plan:
- Empty board; Q for actions 0..8 = {3,7,-2,7,0,1,5,6,2} -> act_action=1, act_qmax=7, act_none=0. act_valid first high at T+11.
- Board with cells 1,3 = X and 4 = O; same Q values -> act_action=7, act_qmax=6.
- Only cell 8 empty, Q[8]=-128 -> act_action=8, act_qmax=-128. Full board (all 01/10) -> act_none=1, act_action=4'hF, act_qmax=0.
- act_ready held low 5 cycles after act_valid, while req_state changes -> outputs stable, req_ready=0. Accept the next request 1 cycle after the handshake.
- rst_n low at T+5 mid-scan -> IDLE next edge, q_rd_en=0, act_valid never asserts, req_ready=1. A fresh request completes normally.
- With POLICY_CTRL_EPS_EXPLORE_EN and EPS_THRESH=8'hFF, empty board, captured start=4 -> act_explore=1, act_action=4.

Source files
------------

// File: rtl/policy_pkg.sv
// Shared types, constants and board helpers for the tic-tac-toe policy controller.
package policy_pkg;

  localparam int Q_W     = 8;
  localparam int N_CELLS = 9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [3:0] ACT_NONE   = 4'hF;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [7:0] EPS_THRESH = 8'd26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [1:0] get_cell(input logic [17:0] board, input logic [3:0] idx);
    logic [17:0] sh;
    sh = board >> {idx, 1'b0};
    return sh[1:0];
  endfunction

  function automatic logic cell_empty(input logic [17:0] board, input logic [3:0] idx);
    return get_cell(board, idx) == CELL_EMPTY;
  endfunction

endpackage

// File: rtl/policy_ctrl_lfsr8.sv
// Seeded 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with advance enable.
// Compiled only when POLICY_CTRL_EPS_EXPLORE_EN is defined, its sole user.
`ifdef POLICY_CTRL_EPS_EXPLORE_EN
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/policy_ctrl.sv
// Picks the agent's move: scans 9 Q-values, masks occupied cells, returns the argmax.
// Optional epsilon-greedy exploration: define POLICY_CTRL_EPS_EXPLORE_EN.
module policy_ctrl
  import policy_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [17:0]    req_state,
  output logic           q_rd_en,
  output logic [17:0]    q_rd_state,
  output logic [3:0]     q_rd_action,
  input  logic [Q_W-1:0] q_rd_data,
  output logic           act_valid,
  input  logic           act_ready,
  output logic [3:0]     act_action,
  output logic           act_none,
  output logic [Q_W-1:0] act_qmax,
  output logic           act_explore
);

  state_e                state_q, state_d;
  logic [17:0]           board_q, board_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rd_en_q, rd_en_d;
  logic [3:0]            rd_action_q, rd_action_d;
  logic                  pend_q, pend_d;
  logic [3:0]            pend_idx_q, pend_idx_d;
  logic                  found_q, found_d;
  logic signed [Q_W-1:0] max_q, max_d;
  logic [3:0]            idx_q, idx_d;
  logic                  act_valid_q, act_valid_d;
  logic [3:0]            act_action_q, act_action_d;
  logic                  act_none_q, act_none_d;
  logic [Q_W-1:0]        act_qmax_q, act_qmax_d;
  logic                  act_explore_q, act_explore_d;

  logic                  accept_s;
  logic                  upd_s;
  logic                  explore_now_s;
  logic                  pick_hit_s;
  logic [3:0]            pick_idx_s;
  logic [Q_W-1:0]        pick_q_s;

  assign accept_s = (state_q == ST_IDLE) && req_valid && req_ready_q;

`ifdef POLICY_CTRL_EPS_EXPLORE_EN
  logic [7:0]     lfsr_s;
  logic           explore_q, explore_d;
  logic [3:0]     start_q, start_d;
  logic [4:0]     cell_s;
  logic [Q_W-1:0] qv_q [N_CELLS];
  logic [Q_W-1:0] qv_d [N_CELLS];

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .lfsr_o (lfsr_s)
  );

  // Every returned Q-value is kept so the exploratory cell can report its own value.
  always_comb begin
    qv_d = qv_q;
    if (pend_q) begin
      qv_d[pend_idx_q] = q_rd_data;
    end else begin
      qv_d = qv_q;
    end
    explore_d = explore_q;
    start_d   = start_q;
    if (accept_s) begin
      explore_d = (lfsr_s < EPS_THRESH);
      start_d   = (lfsr_s[3:0] >= 4'd9) ? (lfsr_s[3:0] - 4'd9) : lfsr_s[3:0];
    end else begin
      explore_d = explore_q;
    end
    pick_hit_s = 1'b0;
    pick_idx_s = ACT_NONE;
    pick_q_s   = '0;
    cell_s     = 5'd0;
    for (int i = 0; i < N_CELLS; i++) begin
      cell_s = {1'b0, start_q} + 5'(i);
      if (cell_s >= 5'd9) begin
        cell_s = cell_s - 5'd9;
      end else begin
        cell_s = cell_s;
      end
      if (!pick_hit_s && cell_empty(board_q, cell_s[3:0])) begin
        pick_hit_s = 1'b1;
        pick_idx_s = cell_s[3:0];
        pick_q_s   = qv_d[cell_s[3:0]];
      end else begin
        pick_hit_s = pick_hit_s;
      end
    end
    explore_now_s = explore_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      explore_q <= 1'b0;
      start_q   <= 4'd0;
      for (int i = 0; i < N_CELLS; i++) qv_q[i] <= '0;
    end else begin
      explore_q <= explore_d;
      start_q   <= start_d;
      qv_q      <= qv_d;
    end
  end
`else
  assign explore_now_s = 1'b0;
  assign pick_hit_s    = 1'b0;
  assign pick_idx_s    = ACT_NONE;
  assign pick_q_s      = '0;
`endif

  // Next state; the compare runs one cycle behind the read it belongs to.
  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    req_ready_d   = req_ready_q;
    rd_en_d       = rd_en_q;
    rd_action_d   = rd_action_q;
    pend_d        = rd_en_q;
    pend_idx_d    = rd_action_q;
    found_d       = found_q;
    max_d         = max_q;
    idx_d         = idx_q;
    act_valid_d   = act_valid_q;
    act_action_d  = act_action_q;
    act_none_d    = act_none_q;
    act_qmax_d    = act_qmax_q;
    act_explore_d = act_explore_q;

    upd_s = pend_q && cell_empty(board_q, pend_idx_q) &&
            (!found_q || ($signed(q_rd_data) > max_q));
    if (upd_s) begin
      found_d = 1'b1;
      max_d   = $signed(q_rd_data);
      idx_d   = pend_idx_q;
    end else begin
      found_d = found_q;
    end

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        rd_en_d     = 1'b0;
        if (accept_s) begin
          board_d     = req_state;
          found_d     = 1'b0;
          rd_en_d     = 1'b1;
          rd_action_d = 4'd0;
          req_ready_d = 1'b0;
          state_d     = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (rd_action_q == 4'd8) begin
          rd_en_d     = 1'b0;
          rd_action_d = 4'd0;
          state_d     = ST_DRAIN;
        end else begin
          rd_action_d = rd_action_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        act_valid_d = 1'b1;
        state_d     = ST_DONE;
        if (!found_d) begin
          act_none_d    = 1'b1;
          act_action_d  = ACT_NONE;
          act_qmax_d    = '0;
          act_explore_d = 1'b0;
        end else if (explore_now_s && pick_hit_s) begin
          act_none_d    = 1'b0;
          act_action_d  = pick_idx_s;
          act_qmax_d    = pick_q_s;
          act_explore_d = 1'b1;
        end else begin
          act_none_d    = 1'b0;
          act_action_d  = idx_d;
          act_qmax_d    = max_d;
          act_explore_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (act_ready) begin
          act_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          act_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rd_en_d     = 1'b0;
        req_ready_d = 1'b1;
        act_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      board_q       <= 18'd0;
      req_ready_q   <= 1'b1;
      rd_en_q       <= 1'b0;
      rd_action_q   <= 4'd0;
      pend_q        <= 1'b0;
      pend_idx_q    <= 4'd0;
      found_q       <= 1'b0;
      max_q         <= '0;
      idx_q         <= 4'd0;
      act_valid_q   <= 1'b0;
      act_action_q  <= ACT_NONE;
      act_none_q    <= 1'b0;
      act_qmax_q    <= '0;
      act_explore_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      req_ready_q   <= req_ready_d;
      rd_en_q       <= rd_en_d;
      rd_action_q   <= rd_action_d;
      pend_q        <= pend_d;
      pend_idx_q    <= pend_idx_d;
      found_q       <= found_d;
      max_q         <= max_d;
      idx_q         <= idx_d;
      act_valid_q   <= act_valid_d;
      act_action_q  <= act_action_d;
      act_none_q    <= act_none_d;
      act_qmax_q    <= act_qmax_d;
      act_explore_q <= act_explore_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign q_rd_en     = rd_en_q;
  assign q_rd_state  = board_q;
  assign q_rd_action = rd_action_q;
  assign act_valid   = act_valid_q;
  assign act_action  = act_action_q;
  assign act_none    = act_none_q;
  assign act_qmax    = act_qmax_q;
  assign act_explore = act_explore_q;

endmodule

// File: tb/tb_policy_ctrl.sv
// Self-checking bench for policy_ctrl (default greedy build) with a Q-table RAM model.
module tb_policy_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [17:0] req_state;
  logic        q_rd_en;
  logic [17:0] q_rd_state;
  logic [3:0]  q_rd_action;
  logic [7:0]  q_rd_data;
  logic        act_valid;
  logic        act_ready;
  logic [3:0]  act_action;
  logic        act_none;
  logic [7:0]  act_qmax;
  logic        act_explore;

  int total = 0;
  int bad   = 0;
  int qtab [9];

  policy_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_state   (req_state),
    .q_rd_en     (q_rd_en),
    .q_rd_state  (q_rd_state),
    .q_rd_action (q_rd_action),
    .q_rd_data   (q_rd_data),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .act_action  (act_action),
    .act_none    (act_none),
    .act_qmax    (act_qmax),
    .act_explore (act_explore)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q-table RAM: one-cycle read latency, junk on the bus when no read was issued.
  always @(posedge clk) begin
    if (q_rd_en && q_rd_action < 4'd9) q_rd_data <= 8'(qtab[q_rd_action]);
    else                               q_rd_data <= 8'($urandom);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: maximum Q over empty cells, then the lowest empty cell holding it.
  task automatic model(input logic [17:0] b, output logic [3:0] a, output logic none,
                       output logic [7:0] qm);
    int best;
    bit any;
    any  = 0;
    best = -1000;
    for (int i = 0; i < 9; i++)
      if (((b >> (2 * i)) & 18'd3) == 18'd0) begin
        any = 1;
        if (qtab[i] > best) best = qtab[i];
      end
    a = 4'hF; none = 1'b1; qm = 8'd0;
    if (any) begin
      none = 1'b0;
      qm   = 8'(best);
      for (int i = 8; i >= 0; i--)
        if ((((b >> (2 * i)) & 18'd3) == 18'd0) && qtab[i] == best) a = 4'(i);
    end
  endtask

  task automatic run_req(input string nm, input logic [17:0] b, input int hold);
    logic [3:0] ea;
    logic       en;
    logic [7:0] eq;
    int         w;
    w = 0;
    while (!req_ready && w < 20) begin step(); w++; end
    check_eq({nm, ".ready_pre"}, 32'(req_ready), 32'd1);
    model(b, ea, en, eq);
    req_valid = 1'b1;
    req_state = b;
    step();
    for (int k = 0; k < 9; k++) begin
      check_eq({nm, ".rd_en"}, 32'(q_rd_en), 32'd1);
      check_eq({nm, ".rd_action"}, 32'(q_rd_action), 32'(k));
      check_eq({nm, ".rd_state"}, 32'(q_rd_state), 32'(b));
      check_eq({nm, ".ready_busy"}, 32'(req_ready), 32'd0);
      req_state = 18'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      step();
    end
    req_valid = 1'b0;
    check_eq({nm, ".valid_early"}, 32'(act_valid), 32'd0);
    check_eq({nm, ".rd_en_drain"}, 32'(q_rd_en), 32'd0);
    step();
    for (int h = 0; h <= hold; h++) begin
      check_eq({nm, ".valid"}, 32'(act_valid), 32'd1);
      check_eq({nm, ".action"}, 32'(act_action), 32'(ea));
      check_eq({nm, ".none"}, 32'(act_none), 32'(en));
      check_eq({nm, ".qmax"}, 32'(act_qmax), 32'(eq));
      check_eq({nm, ".explore"}, 32'(act_explore), 32'd0);
      check_eq({nm, ".ready_done"}, 32'(req_ready), 32'd0);
      if (h < hold) begin
        req_state = 18'($urandom);
        req_valid = 1'($urandom_range(0, 1));
        step();
      end
    end
    req_valid = 1'b0;
    act_ready = 1'b1;
    step();
    act_ready = 1'b0;
    check_eq({nm, ".valid_after"}, 32'(act_valid), 32'd0);
    check_eq({nm, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base [9];
    int seen;
    logic [17:0] b;
    base = '{3, 7, -2, 7, 0, 1, 5, 6, 2};

    rst_n = 1'b0; req_valid = 1'b0; req_state = 18'd0; act_ready = 1'b0;
    qtab = base;
    repeat (3) step();
    check_eq("rst.req_ready", 32'(req_ready), 32'd1);
    check_eq("rst.rd_en", 32'(q_rd_en), 32'd0);
    check_eq("rst.rd_action", 32'(q_rd_action), 32'd0);
    check_eq("rst.rd_state", 32'(q_rd_state), 32'd0);
    check_eq("rst.act_valid", 32'(act_valid), 32'd0);
    check_eq("rst.act_action", 32'(act_action), 32'hF);
    check_eq("rst.act_none", 32'(act_none), 32'd0);
    check_eq("rst.act_qmax", 32'(act_qmax), 32'd0);
    check_eq("rst.act_explore", 32'(act_explore), 32'd0);
    rst_n = 1'b1;
    step();

    run_req("empty", 18'h00000, 0);
    run_req("partial", 18'h00244, 5);
    qtab = '{127, 127, 127, 127, 127, 127, 127, 127, -128};
    run_req("last_only", 18'h05555, 1);
    run_req("full", 18'h25555, 0);

    // Abandon a request with a reset in the middle of the scan.
    qtab = base;
    req_valid = 1'b1; req_state = 18'h00000;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    check_eq("midrst.rd_en", 32'(q_rd_en), 32'd0);
    check_eq("midrst.ready", 32'(req_ready), 32'd1);
    check_eq("midrst.valid", 32'(act_valid), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      step();
      if (act_valid) seen++;
    end
    check_eq("midrst.no_result", 32'(seen), 32'd0);
    run_req("after_rst", 18'h00000, 2);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 9; i++) begin
        b[2*i +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        if (n % 2 == 0) qtab[i] = int'($urandom_range(0, 3)) - 2;
        else            qtab[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_req($sformatf("rnd%0d", n), b, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
